hazard_ctrl_gen: RTL and testbench
==================================

Name: hazard_ctrl_gen

Overview:
- Parametrised hazard/forwarding controller for the pipelined core.
- Generalises RAW detection to NSTAGE downstream forwarding sources, with per-stage data-ready flags in place of a fixed load check.
- Adds a multi-cycle-execute stall FSM with a timeout error, plus saturating stall and flush performance counters.
- Sits in ID and drives the PC, IF/ID, ID/EX and EX/MEM keep/flush enables.

Parameters:
XLEN, 32, register/data width
RA_W, 5, register address width
NSTAGE, 3, number of forwarding source stages; index 0 = nearest (EX), NSTAGE-1 = farthest (WB)
MC_TIMEOUT, 64, max BUSY cycles before error (>=2)
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rR1_ID  in  RA_W  source reg 1 of ID instruction
rR2_ID  in  RA_W  source reg 2 of ID instruction
rD1_used  in  1  ID uses rs1
rD2_used  in  1  ID uses rs2
src_we  in  NSTAGE  stage k writes the register file
src_wr  in  NSTAGE*RA_W  dest reg of stage k, slice [k*RA_W +: RA_W]
src_wd  in  NSTAGE*XLEN  write data of stage k, slice [k*XLEN +: XLEN]
src_rdy  in  NSTAGE  stage k write data already valid (0 = load or multi-cycle result still pending)
npc_op  in  1  taken branch/jump redirect resolved in EX
mc_start  in  1  multi-cycle op present in EX this cycle
mc_done  in  1  multi-cycle unit result valid this cycle
cnt_clr  in  1  synchronous counter clear
rD1_op  out  1  forward rs1
rD2_op  out  1  forward rs2
rD1_forward  out  XLEN  forwarded rs1 data
rD2_forward  out  XLEN  forwarded rs2 data
keep_PC  out  1  hold PC
keep_IF_ID  out  1  hold IF/ID
keep_ID_EX  out  1  hold ID/EX
flush_IF_ID  out  1  clear IF/ID
flush_ID_EX  out  1  clear ID/EX
flush_EX_MEM  out  1  insert bubble into EX/MEM
mc_busy  out  1  multi-cycle stall active
mc_err  out  1  sticky timeout error
stall_cnt  out  CNT_W  cycles with keep_PC=1
flush_cnt  out  CNT_W  cycles with flush_IF_ID=1

Behaviour:
- Match rule, stage k, operand s: src_we[k] && wr_k!=0 && wr_k==rRs_ID && rDs_used.
- Forwarding selects the lowest-index matching stage. rDs_op=1 and rDs_forward=wd_k when any stage matches; otherwise rDs_op=0 and rDs_forward=0.
- Data-hazard stall: the selected stage has src_rdy[k]=0. Only the selected stage is checked, never farther ones.
- mc FSM states IDLE, BUSY, ERR. Reset state is IDLE, with tmo counter=0.
- IDLE: mc_start && !mc_done -> BUSY with tmo=1. mc_start && mc_done is a single-cycle op: no stall, stay in IDLE.
- BUSY: mc_done -> IDLE, and that cycle is not stalled. Otherwise tmo++. When tmo==MC_TIMEOUT and no done -> ERR.
- ERR: mc_err=1 and all keeps are held permanently. Only reset exits ERR.
- mc_busy = (state==BUSY && !mc_done) || (state==IDLE && mc_start && !mc_done) || state==ERR.
- Priority, mutually exclusive, highest first:
  1. mc_busy: keep_PC=keep_IF_ID=keep_ID_EX=1, flush_EX_MEM=1, all other flushes 0.
  2. npc_op: flush_IF_ID=flush_ID_EX=1, all keeps 0; a simultaneous data-hazard stall is discarded.
  3. Data-hazard stall: keep_PC=keep_IF_ID=1, flush_ID_EX=1.
  4. Otherwise all keep/flush outputs are 0.
- Forwarding outputs are computed in every case, independent of the stall/flush decision.
- While rst_n=0: all keep/flush outputs = 0, mc_busy=0, mc_err=0, counters=0.
- Counters update on posedge clk and saturate at all-ones (no wrap).
  - stall_cnt increments when keep_PC=1; flush_cnt increments when flush_IF_ID=1.
  - cnt_clr loads 0 and overrides increment in the same cycle.
- No latency on control/forward outputs: combinational from inputs and state. FSM and counters are registered.

Test Plan:
- Stage0 we=1, wr=5, wd=0x11, rdy=1; stage2 we=1, wr=5, wd=0x22; rR1=5, used=1 -> rD1_op=1, rD1_forward=0x11, no stall. Repeat with wr=0 everywhere -> rD1_op=0, forward=0.
- Stage0 wr=7, rdy=0 (load); rR2=7, used=1 -> keep_PC=keep_IF_ID=flush_ID_EX=1. Assert npc_op the same cycle -> keeps 0, flush_IF_ID=flush_ID_EX=1.
- mc_start at cycle 0, mc_done at cycle 4 -> mc_busy/keeps/flush_EX_MEM=1 for cycles 0-3, 0 at cycle 4, state IDLE; stall_cnt=4.
- mc_start && mc_done same cycle -> no stall, state stays IDLE.
- MC_TIMEOUT=8, mc_start then no mc_done -> ERR after 8 BUSY cycles, mc_err=1 sticky. rst_n low mid-ERR -> all outputs 0 asynchronously, IDLE after release.
- CNT_W=4, hold npc_op 20 cycles -> flush_cnt saturates at 15. cnt_clr=1 with npc_op=1 -> flush_cnt=0 next cycle.

Source files
------------

// File: rtl/hazard_ctrl_gen_if.sv
// Hazard controller bus: ID operand info, forwarding sources, multi-cycle
// handshake and counter control in; forwarding, keep/flush and status out.
//   master : drives the ID/source/mc inputs, observes controls (core or bench)
//   slave  : the hazard controller itself
interface hazard_ctrl_gen_if #(
  parameter int XLEN   = 32,
  parameter int RA_W   = 5,
  parameter int NSTAGE = 3,
  parameter int CNT_W  = 32
);
  logic [RA_W-1:0]        rR1_ID, rR2_ID;
  logic                   rD1_used, rD2_used;
  logic [NSTAGE-1:0]      src_we;
  logic [NSTAGE*RA_W-1:0] src_wr;
  logic [NSTAGE*XLEN-1:0] src_wd;
  logic [NSTAGE-1:0]      src_rdy;
  logic                   npc_op, mc_start, mc_done, cnt_clr;
  logic                   rD1_op, rD2_op;
  logic [XLEN-1:0]        rD1_forward, rD2_forward;
  logic                   keep_PC, keep_IF_ID, keep_ID_EX;
  logic                   flush_IF_ID, flush_ID_EX, flush_EX_MEM;
  logic                   mc_busy, mc_err;
  logic [CNT_W-1:0]       stall_cnt, flush_cnt;

  modport master (
    output rR1_ID, rR2_ID, rD1_used, rD2_used, src_we, src_wr, src_wd, src_rdy,
           npc_op, mc_start, mc_done, cnt_clr,
    input  rD1_op, rD2_op, rD1_forward, rD2_forward, keep_PC, keep_IF_ID,
           keep_ID_EX, flush_IF_ID, flush_ID_EX, flush_EX_MEM, mc_busy, mc_err,
           stall_cnt, flush_cnt
  );
  modport slave (
    input  rR1_ID, rR2_ID, rD1_used, rD2_used, src_we, src_wr, src_wd, src_rdy,
           npc_op, mc_start, mc_done, cnt_clr,
    output rD1_op, rD2_op, rD1_forward, rD2_forward, keep_PC, keep_IF_ID,
           keep_ID_EX, flush_IF_ID, flush_ID_EX, flush_EX_MEM, mc_busy, mc_err,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl_gen.sv
// Hazard / forwarding controller sitting in ID.
//   clk, rst_n : clock, async active-low reset
//   bus        : hazard_ctrl_gen_if.slave (operands, NSTAGE forwarding sources,
//                multi-cycle handshake, counter clear; forward data,
//                PC/IF-ID/ID-EX/EX-MEM keep+flush, mc status, perf counters)
// Control and forward outputs are combinational; the multi-cycle FSM and the
// saturating counters are the only state.

// Per-source-stage RAW match for both ID operands.
module hazard_src_match #(
  parameter int RA_W = 5
) (
  input  logic            we,
  input  logic [RA_W-1:0] wr,
  input  logic [RA_W-1:0] rs1,
  input  logic [RA_W-1:0] rs2,
  input  logic            used1,
  input  logic            used2,
  output logic            hit1,
  output logic            hit2
);
  logic wv;
  assign wv   = we && (wr != '0);   // x0 is never a real producer
  assign hit1 = wv && used1 && (wr == rs1);
  assign hit2 = wv && used2 && (wr == rs2);
endmodule

module hazard_ctrl_gen #(
  parameter int XLEN       = 32,
  parameter int RA_W       = 5,
  parameter int NSTAGE     = 3,
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  hazard_ctrl_gen_if.slave bus
);
  localparam int TMO_W = $clog2(MC_TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_ERR} mc_st_e;

  mc_st_e           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  logic [NSTAGE-1:0] hit1, hit2;
  logic              op1, op2, rdy1, rdy2, hz;
  logic [XLEN-1:0]   fwd1, fwd2;
  logic              busy, keep_pc, keep_ifid, keep_idex;
  logic              fl_ifid, fl_idex, fl_exmem;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_src
    hazard_src_match #(.RA_W(RA_W)) u_match (
      .we   (bus.src_we[k]),
      .wr   (bus.src_wr[k*RA_W +: RA_W]),
      .rs1  (bus.rR1_ID),
      .rs2  (bus.rR2_ID),
      .used1(bus.rD1_used),
      .used2(bus.rD2_used),
      .hit1 (hit1[k]),
      .hit2 (hit2[k])
    );
  end

  // Walk far-to-near so the nearest (lowest index) match wins. Readiness is
  // taken only from the selected stage: older copies are stale anyway.
  always_comb begin
    op1 = 1'b0; fwd1 = '0; rdy1 = 1'b1;
    op2 = 1'b0; fwd2 = '0; rdy2 = 1'b1;
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      if (hit1[k]) begin
        op1 = 1'b1; fwd1 = bus.src_wd[k*XLEN +: XLEN]; rdy1 = bus.src_rdy[k];
      end
      if (hit2[k]) begin
        op2 = 1'b1; fwd2 = bus.src_wd[k*XLEN +: XLEN]; rdy2 = bus.src_rdy[k];
      end
    end
  end

  assign hz = (op1 && !rdy1) || (op2 && !rdy2);

  // Multi-cycle FSM next state. tmo counts BUSY cycles, the launch cycle
  // already counts as the first.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      ST_IDLE: if (bus.mc_start && !bus.mc_done) begin
        state_d = ST_BUSY;
        tmo_d   = TMO_W'(1);
      end
      ST_BUSY: begin
        if (bus.mc_done) begin
          state_d = ST_IDLE;
          tmo_d   = '0;
        end else if (tmo_q == TMO_W'(MC_TIMEOUT)) begin
          state_d = ST_ERR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = ST_ERR;   // only reset leaves ERR
    endcase
  end

  // Stall/flush priority: mc stall > redirect > data hazard.
  always_comb begin
    busy      = 1'b0;
    keep_pc   = 1'b0; keep_ifid = 1'b0; keep_idex = 1'b0;
    fl_ifid   = 1'b0; fl_idex   = 1'b0; fl_exmem  = 1'b0;
    if (rst_n) begin
      busy = (state_q == ST_BUSY && !bus.mc_done) ||
             (state_q == ST_IDLE && bus.mc_start && !bus.mc_done) ||
             (state_q == ST_ERR);
      if (busy) begin
        keep_pc = 1'b1; keep_ifid = 1'b1; keep_idex = 1'b1; fl_exmem = 1'b1;
      end else if (bus.npc_op) begin
        fl_ifid = 1'b1; fl_idex = 1'b1;
      end else if (hz) begin
        keep_pc = 1'b1; keep_ifid = 1'b1; fl_idex = 1'b1;
      end
    end
  end

  // Saturating counters; clear beats increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (keep_pc && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
      if (fl_ifid && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tmo_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.rD1_op       = op1;
  assign bus.rD2_op       = op2;
  assign bus.rD1_forward  = fwd1;
  assign bus.rD2_forward  = fwd2;
  assign bus.keep_PC      = keep_pc;
  assign bus.keep_IF_ID   = keep_ifid;
  assign bus.keep_ID_EX   = keep_idex;
  assign bus.flush_IF_ID  = fl_ifid;
  assign bus.flush_ID_EX  = fl_idex;
  assign bus.flush_EX_MEM = fl_exmem;
  assign bus.mc_busy      = busy;
  assign bus.mc_err       = rst_n && (state_q == ST_ERR);
  assign bus.stall_cnt    = stall_cnt_q;
  assign bus.flush_cnt    = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl_gen.sv
// Bench for hazard_ctrl_gen: each cycle the driver sets inputs, a reference
// model pushes the expected outputs to a queue, and a negedge monitor pops
// and compares them against the DUT.
module tb_hazard_ctrl_gen;
  localparam int XLEN = 32, RA_W = 5, NS = 3, MCT = 8, CW = 4;

  logic clk = 1'b1;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_gen_if #(.XLEN(XLEN), .RA_W(RA_W), .NSTAGE(NS), .CNT_W(CW)) bus ();

  hazard_ctrl_gen #(.XLEN(XLEN), .RA_W(RA_W), .NSTAGE(NS), .MC_TIMEOUT(MCT),
                    .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic            op1, op2;
    logic [XLEN-1:0] f1, f2;
    logic [2:0]      keep;   // {PC, IF_ID, ID_EX}
    logic [2:0]      flush;  // {IF_ID, ID_EX, EX_MEM}
    logic            busy, err;
    logic [CW-1:0]   sc, fc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_chk = 0, n_err = 0;

  // model state
  int            ms = 0;     // 0 idle, 1 busy, 2 err
  int            mtmo = 0;
  logic [CW-1:0] msc = '0, mfc = '0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push_exp();
    exp_t e;
    logic f1, f2, r1, r2, hz, bsy;
    logic [RA_W-1:0] w;
    e = '0; f1 = 0; f2 = 0; r1 = 1; r2 = 1;
    for (int k = 0; k < NS; k++) begin
      w = bus.src_wr[k*RA_W +: RA_W];
      if (!f1 && bus.src_we[k] && w != 0 && w == bus.rR1_ID && bus.rD1_used) begin
        f1 = 1; e.op1 = 1; e.f1 = bus.src_wd[k*XLEN +: XLEN]; r1 = bus.src_rdy[k];
      end
      if (!f2 && bus.src_we[k] && w != 0 && w == bus.rR2_ID && bus.rD2_used) begin
        f2 = 1; e.op2 = 1; e.f2 = bus.src_wd[k*XLEN +: XLEN]; r2 = bus.src_rdy[k];
      end
    end
    hz = (e.op1 && !r1) || (e.op2 && !r2);
    if (!rst_n) begin
      ms = 0; mtmo = 0; msc = '0; mfc = '0;
    end else begin
      bsy = (ms == 1 && !bus.mc_done) || (ms == 0 && bus.mc_start && !bus.mc_done) || ms == 2;
      if (bsy)             begin e.keep = 3'b111; e.flush = 3'b001; end
      else if (bus.npc_op) begin e.keep = 3'b000; e.flush = 3'b110; end
      else if (hz)         begin e.keep = 3'b110; e.flush = 3'b010; end
      e.busy = bsy;
      e.err  = (ms == 2);
      e.sc   = msc;
      e.fc   = mfc;
      if (bus.cnt_clr) begin msc = '0; mfc = '0; end
      else begin
        if (e.keep[2]  && msc != 4'hF) msc = msc + 1;
        if (e.flush[2] && mfc != 4'hF) mfc = mfc + 1;
      end
      case (ms)
        0: if (bus.mc_start && !bus.mc_done) begin ms = 1; mtmo = 1; end
        1: if (bus.mc_done) begin ms = 0; mtmo = 0; end
           else if (mtmo == MCT) ms = 2;
           else mtmo++;
        default: ms = 2;
      endcase
    end
    q.push_back(e);
  endtask

  // one cycle: record expectation for current inputs, advance to posedge+1
  task automatic go();
    push_exp();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.rR1_ID = '0; bus.rR2_ID = '0; bus.rD1_used = 0; bus.rD2_used = 0;
    bus.src_we = '0; bus.src_wr = '0; bus.src_wd = '0; bus.src_rdy = '1;
    bus.npc_op = 0; bus.mc_start = 0; bus.mc_done = 0; bus.cnt_clr = 0;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("rD1_op",       bus.rD1_op,       mon_e.op1);
      chk("rD2_op",       bus.rD2_op,       mon_e.op2);
      chk("rD1_forward",  bus.rD1_forward,  mon_e.f1);
      chk("rD2_forward",  bus.rD2_forward,  mon_e.f2);
      chk("keep",  {bus.keep_PC, bus.keep_IF_ID, bus.keep_ID_EX}, mon_e.keep);
      chk("flush", {bus.flush_IF_ID, bus.flush_ID_EX, bus.flush_EX_MEM}, mon_e.flush);
      chk("mc_busy",   bus.mc_busy,   mon_e.busy);
      chk("mc_err",    bus.mc_err,    mon_e.err);
      chk("stall_cnt", bus.stall_cnt, mon_e.sc);
      chk("flush_cnt", bus.flush_cnt, mon_e.fc);
    end
  end

  initial begin
    // reset, with mc_start/npc asserted to show outputs stay quiet
    idle_in(); bus.mc_start = 1; bus.npc_op = 1;
    go(); go();
    rst_n = 1; idle_in(); go();

    // nearest stage wins; wr=0 never forwards
    bus.src_we = 3'b101; bus.src_wr = {5'd5, 5'd0, 5'd5};
    bus.src_wd = {32'h22, 32'h0, 32'h11}; bus.rR1_ID = 5; bus.rD1_used = 1;
    go();
    bus.src_wr = '0; go();

    // stage1 not ready but stage0 selected -> no stall; both operands
    bus.src_we = 3'b011; bus.src_wr = {5'd0, 5'd9, 5'd9};
    bus.src_wd = {32'h0, 32'h33, 32'h44}; bus.src_rdy = 3'b101;
    bus.rR1_ID = 9; bus.rR2_ID = 9; bus.rD1_used = 1; bus.rD2_used = 1;
    go();
    bus.rD2_used = 0; go();

    // load-use on rs2, then with a redirect the same cycle
    idle_in(); bus.src_we = 3'b001; bus.src_wr = {5'd0, 5'd0, 5'd7};
    bus.src_wd = {32'h0, 32'h0, 32'h77}; bus.src_rdy = 3'b110;
    bus.rR2_ID = 7; bus.rD2_used = 1;
    go();
    bus.npc_op = 1; go();
    // only farthest stage matches and is pending
    idle_in(); bus.src_we = 3'b100; bus.src_wr = {5'd7, 5'd0, 5'd0};
    bus.src_wd = {32'h99, 32'h0, 32'h0}; bus.src_rdy = 3'b011;
    bus.rR2_ID = 7; bus.rD2_used = 1;
    go();

    // multi-cycle op: start c0, done c4 -> 4 stalled cycles
    idle_in(); bus.cnt_clr = 1; go();
    idle_in(); bus.mc_start = 1; go();
    bus.mc_start = 0; go();
    bus.npc_op = 1; go();          // redirect hidden behind mc stall
    bus.npc_op = 0; go();
    bus.mc_done = 1; go();
    idle_in();
    chk("stall_cnt_mc", bus.stall_cnt, 4);
    go();

    // single-cycle op: no stall
    bus.mc_start = 1; bus.mc_done = 1; go();
    idle_in(); go();

    // flush counter saturation and clear-overrides-increment
    bus.cnt_clr = 1; go();
    idle_in(); bus.npc_op = 1;
    repeat (20) go();
    chk("flush_sat", bus.flush_cnt, 15);
    bus.cnt_clr = 1; go();
    chk("flush_clr", bus.flush_cnt, 0);
    idle_in(); go();

    // random mix
    repeat (40) begin
      bus.src_we   = NS'($urandom);
      bus.src_rdy  = NS'($urandom);
      bus.src_wr   = {RA_W'($urandom_range(0, 3)), RA_W'($urandom_range(0, 3)), RA_W'($urandom_range(0, 3))};
      bus.src_wd   = {$urandom, $urandom, $urandom};
      bus.rR1_ID   = RA_W'($urandom_range(0, 3));
      bus.rR2_ID   = RA_W'($urandom_range(0, 3));
      bus.rD1_used = 1'($urandom); bus.rD2_used = 1'($urandom);
      bus.npc_op   = ($urandom_range(0, 3) == 0);
      bus.mc_start = ($urandom_range(0, 5) == 0);
      bus.mc_done  = 1'($urandom);
      bus.cnt_clr  = ($urandom_range(0, 15) == 0);
      go();
    end

    // timeout: start, no done -> ERR after MCT busy cycles, sticky
    idle_in(); bus.mc_start = 1; go();
    bus.mc_start = 0; repeat (10) go();
    bus.mc_done = 1; go(); go();
    chk("mc_err_sticky", bus.mc_err, 1);
    // async reset mid-ERR, then back to IDLE
    rst_n = 0; bus.mc_start = 1; go();
    rst_n = 1; bus.mc_start = 1; bus.mc_done = 1; go();
    idle_in(); go();

    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
